// File: rtl/rec_ctrl.sv
// Transport controller for the audio recorder.
// Turns debounced play/record/stop key levels into record/play enables,
// generates the SRAM sample address with one-cycle read/write strobes and
// tracks the length of the stored take.
module rec_ctrl #(
    parameter int unsigned ADDR_W = 18,
    parameter bit          LOOP   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_play,
    input  logic              key_record,
    input  logic              key_stop,
    input  logic              sample_tick,
    output logic              record,
    output logic              play,
    output logic              wr_stb,
    output logic              rd_stb,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   len,
    output logic              full,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRec   = 2'd1,
        StPlay  = 2'd2,
        StPause = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] CntOne  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CntMax  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   LenOne  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LenFull = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              play_q;
    logic              record_q;
    logic              stop_q;

    logic play_edge;
    logic rec_edge;
    logic stop_edge;
    logic last_sample;

    // Previous key levels for rising-edge detection; cleared by reset so a
    // key held through reset release registers as a fresh press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            play_q   <= 1'b0;
            record_q <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            play_q   <= key_play;
            record_q <= key_record;
            stop_q   <= key_stop;
        end
    end

    assign play_edge   = key_play & ~play_q;
    assign rec_edge    = key_record & ~record_q;
    assign stop_edge   = key_stop & ~stop_q;
    assign last_sample = ({1'b0, cnt_q} == (len - LenOne));

    assign state = state_q;

    // Transport FSM with registered enables, strobes, address and take length.
    // Only edges that act in the current state compete; a tick is processed
    // unless a state-changing edge wins the cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            record  <= 1'b0;
            play    <= 1'b0;
            wr_stb  <= 1'b0;
            rd_stb  <= 1'b0;
            addr    <= '0;
            len     <= '0;
            full    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;
            full   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rec_edge) begin
                        state_q <= StRec;
                        record  <= 1'b1;
                        cnt_q   <= '0;
                        len     <= '0;
                    end else if (play_edge && (len != '0)) begin
                        state_q <= StPlay;
                        play    <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                StRec: begin
                    if (stop_edge) begin
                        state_q <= StIdle;
                        record  <= 1'b0;
                        len     <= {1'b0, cnt_q};
                    end else if (sample_tick) begin
                        wr_stb <= 1'b1;
                        addr   <= cnt_q;
                        cnt_q  <= cnt_q + CntOne;
                        // Last word written: memory is full, take spans the whole SRAM.
                        if (cnt_q == CntMax) begin
                            state_q <= StIdle;
                            record  <= 1'b0;
                            len     <= LenFull;
                            full    <= 1'b1;
                        end
                    end
                end
                StPlay: begin
                    if (stop_edge) begin
                        state_q <= StIdle;
                        play    <= 1'b0;
                    end else if (play_edge) begin
                        state_q <= StPause;
                        play    <= 1'b0;
                    end else if (sample_tick) begin
                        rd_stb <= 1'b1;
                        addr   <= cnt_q;
                        cnt_q  <= cnt_q + CntOne;
                        if (last_sample) begin
                            if (LOOP) begin
                                cnt_q <= '0;
                            end else begin
                                state_q <= StIdle;
                                play    <= 1'b0;
                            end
                        end
                    end
                end
                StPause: begin
                    if (stop_edge) begin
                        state_q <= StIdle;
                    end else if (rec_edge) begin
                        state_q <= StRec;
                        record  <= 1'b1;
                        cnt_q   <= '0;
                        len     <= '0;
                    end else if (play_edge) begin
                        state_q <= StPlay;
                        play    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    record  <= 1'b0;
                    play    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rec_ctrl.md
# rec_ctrl

Transport controller for the audio recorder. It turns debounced play/record/stop key levels into the record/play enables and generates the SRAM sample address and the read/write strobes. It sits directly upstream of the SRAM interface and the ADC/DAC sample paths. It tracks the length of the stored take, stops recording when memory is full, and stops (or loops) playback at the end of the take.

## Interface
- ADDR_W, 18, SRAM word-address width (memory depth 2^ADDR_W samples)
- LOOP, 0, 1 = restart playback at address 0 after the last sample; 0 = return to idle
- clk  in  1  system clock (12 MHz PLL output); all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- key_play  in  1  debounced play/pause key level, active-high, synchronous to clk
- key_record  in  1  debounced record key level, active-high, synchronous to clk
- key_stop  in  1  debounced stop key level, active-high, synchronous to clk
- sample_tick  in  1  one-cycle pulse per stereo sample period (from ADC/DAC LRC edge), synchronous to clk
- record  out  1  high while in REC
- play  out  1  high while in PLAY
- wr_stb  out  1  one-cycle write request to SRAM; addr valid while high
- rd_stb  out  1  one-cycle read request to SRAM; addr valid while high
- addr  out  ADDR_W  SRAM word address
- len  out  ADDR_W+1  number of samples in the stored take (0 = no take)
- full  out  1  one-cycle pulse when recording stops because memory is full
- state  out  2  IDLE=0, REC=1, PLAY=2, PAUSE=3

## Operation
- Edge detection: each key is registered (key_q); edge = key & ~key_q. key_q resets to 0, so a key held through reset release produces an edge on the first cycle it is sampled high.
- Internal counter cnt (ADDR_W bits) holds the next sample index.
- Edge priority when several edges occur in one cycle: stop > record > play.
- IDLE: record edge -> REC, cnt<=0, len<=0. Play edge with len!=0 -> PLAY, cnt<=0. Play edge with len==0 is ignored. Stop edge has no effect.
- REC on a tick: wr_stb<=1, addr<=cnt, cnt<=cnt+1.
  - If cnt==2^ADDR_W-1 on that tick: the sample is stored, len<=2^ADDR_W, full pulses, -> IDLE.
  - Stop edge: len<=cnt, -> IDLE. Play edge is ignored. Record edge is ignored.
- PLAY on a tick: rd_stb<=1, addr<=cnt, cnt<=cnt+1.
  - If cnt==len-1 on that tick: with LOOP=0 -> IDLE; with LOOP=1, cnt<=0 and stay in PLAY.
  - Play edge -> PAUSE with cnt kept. Stop edge -> IDLE. Record edge is ignored.
- PAUSE: ticks are ignored. Play edge -> PLAY, resuming at cnt. Stop edge -> IDLE. Record edge -> REC, with cnt<=0 and len<=0.
- When a key edge and a tick occur in the same cycle, a state-changing edge wins and the tick is dropped (no strobe). A tick coinciding with an ignored edge is processed normally.
- len changes only on entry to REC, on leaving REC, and on reset. Playback never modifies len.
- At most one of wr_stb/rd_stb is high in any cycle; neither is high outside REC/PLAY.

## Timing
- All outputs are registered. Reset values: state=IDLE, record=0, play=0, wr_stb=0, rd_stb=0, addr=0, len=0, full=0, and internally cnt=0, key_q=0.
- Key edge sampled in cycle n -> state/record/play change visible in cycle n+1.
- Tick in cycle n -> strobe high in cycle n+1 only, with addr = sample index for that whole cycle. addr holds its value after the strobe until the next strobe.
- Full: the final wr_stb (addr=2^ADDR_W-1), full=1, state=IDLE and record=0 all appear in the same cycle.
- Playback end: the last rd_stb (addr=len-1) and state=IDLE appear in the same cycle.
- Back-to-back ticks on consecutive cycles are legal and produce consecutive strobes with incrementing addr.
- Reset asserted mid-operation clears everything immediately, asynchronously; the stored take is forgotten (len=0).

## Test plan
- Reset, then record edge, 5 ticks, stop edge -> wr_stb x5 with addr 0..4, then state=IDLE, len=5, record=0.
- After len=5, play edge, 7 ticks (LOOP=0) -> rd_stb x5 with addr 0..4, state=IDLE one cycle after the 5th tick, no strobe for ticks 6-7.
- Play, 2 ticks, play edge, 3 ticks, play edge, 3 ticks -> addr 0,1, then PAUSE with no strobes, then resume with addr 2,3,4, then IDLE.
- ADDR_W=4: record with 17 ticks -> 16 wr_stb (addr 0..15), full pulse with the 16th strobe, len=16, tick 17 ignored.
- Stop, record and play edges in the same cycle during PLAY, plus a tick -> IDLE, no strobe, len unchanged. Play edge with len=0 in IDLE -> remains IDLE.
- Reset pulled low mid-record after 3 ticks -> all outputs 0 at once; after release, a play edge stays in IDLE (len=0).
